// File: rtl/vga_pixel_pump.sv
// vga_pixel_pump: pops framebuffer FIFO words onto visible pixels, frame-aligned with underflow recovery
module vga_pixel_pump #(
    parameter int          HDISP       = 800,
    parameter int          VDISP       = 480,
    parameter logic [23:0] UFLOW_COLOR = 24'hFF00FF
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst,
    input  logic        enable,
    input  logic        timing_vs,
    input  logic        timing_blank,
    input  logic [23:0] fifo_rdata,
    input  logic        fifo_rempty,
    input  logic        fifo_ready,
    output logic        fifo_read,
    output logic [23:0] rgb,
    output logic        underflow,
    output logic        frame_err,
    output logic        running
);
    localparam int            FRAME   = HDISP * VDISP;
    localparam int            CW      = $clog2(FRAME + 1);
    localparam logic [CW-1:0] FRAME_N = CW'(FRAME);
    localparam logic [2:0]    IDLE = 3'd0, PRIME = 3'd1, WAIT_FRAME = 3'd2, RUN = 3'd3, DRAIN = 3'd4;

    logic [2:0]    state, state_nx;
    logic [CW-1:0] pop_cnt;
    logic [23:0]   rgb_nx;
    logic          vs_d, fsb, in_frame, uflow_hit;

    assign fsb       = vs_d & ~timing_vs;
    assign in_frame  = (state == RUN) | (state == DRAIN);
    assign uflow_hit = (state == RUN) & timing_blank & fifo_rempty;
    assign running   = state == RUN;

    // DRAIN pops regardless of BLANK to discard the rest of the frame, capped at one frame's worth
    always_comb begin
        fifo_read = (state == RUN)   ? timing_blank & ~fifo_rempty :
                    (state == DRAIN) ? ~fifo_rempty & (pop_cnt < FRAME_N) : 1'b0;
        rgb_nx    = ~timing_blank    ? 24'd0 :
                    (state == RUN)   ? (fifo_rempty ? UFLOW_COLOR : fifo_rdata) :
                    (state == DRAIN) ? UFLOW_COLOR : 24'd0;
        state_nx  = IDLE;
        case (state)
            IDLE:       state_nx = enable ? PRIME : IDLE;
            PRIME:      state_nx = ~enable ? IDLE : fifo_ready ? WAIT_FRAME : PRIME;
            WAIT_FRAME: state_nx = ~enable ? IDLE : fsb ? RUN : WAIT_FRAME;
            RUN:        state_nx = (fsb & ~enable) ? IDLE : uflow_hit ? DRAIN : RUN;
            DRAIN:      state_nx = ~fsb ? DRAIN : enable ? WAIT_FRAME : IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state     <= IDLE;
            pop_cnt   <= '0;
            vs_d      <= 1'b1;
            rgb       <= '0;
            underflow <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            vs_d      <= timing_vs;
            pop_cnt   <= fsb ? '0 : pop_cnt + CW'(fifo_read);
            rgb       <= rgb_nx;
            underflow <= underflow | uflow_hit;
            frame_err <= fsb & in_frame & (pop_cnt != FRAME_N);
        end
    end
endmodule

// File: tb/tb_vga_pixel_pump.sv
// tb_vga_pixel_pump: directed frame sequence with random pixel data, checked against an expected-picture queue
module tb_vga_pixel_pump;
    localparam logic [23:0] UFLOW = 24'hFF00FF;

    logic        pixel_clk = 0, pixel_rst = 1, enable = 0, timing_vs = 1, timing_blank = 0;
    logic        fifo_rempty = 1, fifo_ready = 0;
    logic [23:0] fifo_rdata = 0;
    logic        fifo_read, underflow, frame_err, running;
    logic [23:0] rgb;
    int          checks = 0, failures = 0, wr_cnt = 0;
    logic [23:0] fq[$], pend[$], expq[$];

    vga_pixel_pump #(.HDISP(8), .VDISP(4), .UFLOW_COLOR(UFLOW)) dut (
        .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .enable(enable),
        .timing_vs(timing_vs), .timing_blank(timing_blank),
        .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty), .fifo_ready(fifo_ready),
        .fifo_read(fifo_read), .rgb(rgb), .underflow(underflow),
        .frame_err(frame_err), .running(running)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want_v);
        checks++;
        assert (got === want_v) else begin
            failures++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, want_v);
        end
    endtask

    task automatic gen(input int n, input bit shown);
        logic [23:0] w;
        for (int i = 0; i < n; i++) begin
            w = {8'($urandom), 16'(wr_cnt)};
            wr_cnt++;
            pend.push_back(w);
            if (shown) expq.push_back(w);
        end
    endtask

    task automatic want(input int n, input logic [23:0] v);
        for (int i = 0; i < n; i++) expq.push_back(v);
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n && pend.size() > 0; i++) fq.push_back(pend.pop_front());
    endtask

    // one pixel clock: drive timing, present FIFO head, pop on accepted read, check outputs
    task automatic cyc(input logic vs, input logic bl, input bit rst, input logic ferr_exp);
        logic pop;
        timing_vs    = vs;
        timing_blank = bl;
        if (rst) begin
            pixel_rst = 1;
            #1;
            chk("rst_rgb", 32'(rgb), 0);
            chk("rst_read", 32'(fifo_read), 0);
            chk("rst_running", 32'(running), 0);
            chk("rst_underflow", 32'(underflow), 0);
            fq.delete();
        end
        fifo_rempty = fq.size() == 0;
        fifo_rdata  = fifo_rempty ? 24'd0 : fq[0];
        #1;
        pop = fifo_read;
        chk("pop_on_empty", 32'(pop & fifo_rempty), 0);
        @(posedge pixel_clk);
        #1;
        pixel_rst = 0;
        if (pop) void'(fq.pop_front());
        if (bl) begin
            chk("exp_available", 32'(expq.size() > 0), 1);
            if (expq.size() > 0) chk("rgb_visible", 32'(rgb), 32'(expq.pop_front()));
        end else chk("rgb_blank", 32'(rgb), 0);
        chk("frame_err", 32'(frame_err), 32'(ferr_exp));
    endtask

    // frame: VS low 2 cycles, 2 porch, 4 lines of 8 visible + 2 blank, optional extra visible, 2 blank
    task automatic frame(input int extra, input int en_off_at, input int push_at, input int push_n,
                         input int rst_at, input logic ferr_exp);
        for (int c = 0; c < 46 + extra; c++) begin
            if (c == en_off_at) enable = 0;
            if (c == push_at) load(push_n);
            cyc(c >= 2, (c >= 4 && c < 44 && (c - 4) % 10 < 8) || (c >= 44 && c < 44 + extra),
                c == rst_at, c == 0 ? ferr_exp : 1'b0);
        end
    endtask

    initial begin
        repeat (2) @(posedge pixel_clk);
        #1;
        chk("reset_rgb", 32'(rgb), 0);
        chk("reset_underflow", 32'(underflow), 0);
        chk("reset_frame_err", 32'(frame_err), 0);
        chk("reset_running", 32'(running), 0);
        chk("reset_read", 32'(fifo_read), 0);
        pixel_rst  = 0;
        enable     = 1;
        fifo_ready = 1;
        for (int i = 0; i < 32; i++) begin
            pend.push_back(24'(i));
            expq.push_back(24'(i));
        end
        load(32);
        gen(32, 1);
        load(32);
        repeat (3) cyc(1, 0, 0, 0);
        chk("t1_not_running_before_fsb", 32'(running), 0);
        frame(0, -1, -1, 0, -1, 0);
        chk("t1_running", 32'(running), 1);
        frame(0, -1, -1, 0, -1, 0);
        gen(33, 1);
        load(33);
        frame(1, -1, -1, 0, -1, 0);
        gen(32, 1);
        load(32);
        frame(0, 24, -1, 0, -1, 1);
        chk("t5_running_after_drop", 32'(running), 1);
        chk("t5_fifo_drained", fq.size(), 0);
        gen(5, 0);
        load(5);
        want(32, 0);
        frame(0, -1, -1, 0, -1, 0);
        chk("t5_idle", 32'(running), 0);
        chk("t5_no_pops_idle", fq.size(), 5);
        chk("t5_underflow_clear", 32'(underflow), 0);
        fq.delete();
        enable = 1;
        want(32, 0);
        gen(10, 1);
        load(10);
        want(22, UFLOW);
        gen(22, 0);
        want(32, 0);
        gen(32, 1);
        frame(0, -1, -1, 0, -1, 0);
        frame(0, -1, 20, 54, -1, 0);
        chk("t3_underflow", 32'(underflow), 1);
        chk("t3_drain_not_running", 32'(running), 0);
        chk("t3_drain_capped", fq.size(), 32);
        frame(0, -1, -1, 0, -1, 0);
        chk("t3_wait_no_pops", fq.size(), 32);
        frame(0, -1, -1, 0, -1, 0);
        chk("t3_running_again", 32'(running), 1);
        chk("t3_underflow_sticky", 32'(underflow), 1);
        fifo_ready = 0;
        gen(10, 1);
        want(22, 0);
        gen(22, 0);
        load(32);
        frame(0, -1, -1, 0, 16, 0);
        chk("t6_running_after_rst", 32'(running), 0);
        chk("t6_underflow_after_rst", 32'(underflow), 0);
        want(128, 0);
        gen(32, 1);
        load(32);
        repeat (3) frame(0, -1, -1, 0, -1, 0);
        fifo_ready = 1;
        frame(0, -1, -1, 0, -1, 0);
        chk("t2_no_pops_before_fsb", fq.size(), 32);
        frame(0, -1, -1, 0, -1, 0);
        chk("t2_running", 32'(running), 1);
        chk("t2_all_popped", fq.size(), 0);
        enable = 0;
        want(32, 0);
        frame(0, -1, -1, 0, -1, 0);
        chk("end_idle", 32'(running), 0);
        chk("end_exp_consumed", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
